// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Arbitrates a single-port frame buffer between display reads,
//             a small FIFO of writer pixels and a full-frame clear engine.
//             Priority each cycle: display (active region) > buffered write
//             > clear > idle. All memory-port outputs are registered.
//  Ports    :
//     clk_vga, rst_n          pixel clock, asynchronous active-low reset
//     hc_visible, vc_visible  1-based column/line from the timing driver,
//                             0 = not visible
//     wr_valid/wr_ready       writer handshake, wr_addr/wr_data payload
//     clr_req, clr_color      clear request pulse and fill value
//     clr_busy                clear in progress
//     mem_addr/mem_we/mem_wdata  frame-buffer port (registered)
//     mem_rdata               read data, one cycle after the address
//     pix_data/pix_valid      display pixel, two cycles after hc/vc sample
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_arbiter #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int WBUF_DEPTH = 4
) (
   input  logic              clk_vga,
   input  logic              rst_n,
   input  logic [9:0]        hc_visible,
   input  logic [9:0]        vc_visible,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_req,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid
);

   localparam int                PTR_W     = $clog2(WBUF_DEPTH);
   localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] H_ACT_A   = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(WBUF_DEPTH);
   localparam logic [PTR_W-1:0]  ONE_P     = PTR_W'(1);
   localparam logic [PTR_W:0]    ONE_C     = (PTR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_WRITE  = 2'd2,
      S_CLEAR  = 2'd3
   } state_t;

   state_t state, next_state;

   // ------------------------------------------------------------------
   // Display address
   // ------------------------------------------------------------------
   logic              active;
   logic [ADDR_W-1:0] disp_addr;

   assign active    = (hc_visible != 10'd0) && (vc_visible != 10'd0);
   assign disp_addr = (ADDR_W'(vc_visible) - ONE_A) * H_ACT_A
                    + (ADDR_W'(hc_visible) - ONE_A);

   // ------------------------------------------------------------------
   // Write buffer
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
   logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [PTR_W:0]    count;
   logic              fifo_empty, push, pop;

   assign fifo_empty = (count == '0);
   // Ready comes straight from the registered count, so a pop only frees
   // a slot as seen by the writer on the following cycle.
   assign wr_ready   = (count != FULL_CNT);
   assign push       = wr_valid && wr_ready;
   assign pop        = (next_state == S_WRITE);

   always_ff @(posedge clk_vga) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE_P;
         if (pop)  rd_ptr <= rd_ptr + ONE_P;
         case ({push, pop})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Clear engine
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] clr_col;

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         clr_busy <= 1'b0;
         clr_ptr  <= '0;
         clr_col  <= '0;
      end else if (clr_req) begin
         // A new request always restarts from the first pixel.
         clr_busy <= 1'b1;
         clr_ptr  <= '0;
         clr_col  <= clr_color;
      end else if (next_state == S_CLEAR) begin
         if (clr_ptr == LAST_ADDR) begin
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
         end else begin
            clr_ptr  <= clr_ptr + ONE_A;
         end
      end
   end

   // ------------------------------------------------------------------
   // Port owner FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = S_IDLE;
      if (active)
         next_state = S_ACTIVE;
      else if (!fifo_empty)
         next_state = S_WRITE;
      // A clear restarting this cycle skips its stale write at the old
      // pointer; the fill begins at address 0 on the next cycle.
      else if (clr_busy && !clr_req)
         next_state = S_CLEAR;
   end

   // ------------------------------------------------------------------
   // Registered memory port
   // ------------------------------------------------------------------
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         case (next_state)
            S_ACTIVE: begin
               mem_we   <= 1'b0;
               mem_addr <= disp_addr;
            end
            S_WRITE: begin
               mem_we    <= 1'b1;
               mem_addr  <= fifo_addr[rd_ptr];
               mem_wdata <= fifo_data[rd_ptr];
            end
            S_CLEAR: begin
               mem_we    <= 1'b1;
               mem_addr  <= clr_ptr;
               mem_wdata <= clr_col;
            end
            default: mem_we <= 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Display output: state marks a read address on the port this cycle,
   // its data returns one cycle later.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) pix_valid <= 1'b0;
      else        pix_valid <= (state == S_ACTIVE);
   end

   assign pix_data = pix_valid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_arbiter
//  Purpose  : Directed self-checking bench for vga_fb_arbiter on a reduced
//             16x4 frame with a behavioural synchronous frame-buffer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;

   localparam int H = 16;
   localparam int V = 4;
   localparam int N = H * V;

   logic        clk_vga = 1'b0;
   logic        rst_n;
   logic [9:0]  hc_visible, vc_visible;
   logic        wr_valid, wr_ready;
   logic [18:0] wr_addr;
   logic [11:0] wr_data;
   logic        clr_req;
   logic [11:0] clr_color;
   logic        clr_busy;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata = 12'h000;
   logic [11:0] pix_data;
   logic        pix_valid;

   logic [11:0] mem [0:N-1];
   int          we_cnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk_vga = ~clk_vga;

   vga_fb_arbiter #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(19), .DATA_W(12), .WBUF_DEPTH(4)
   ) dut (
      .clk_vga(clk_vga), .rst_n(rst_n),
      .hc_visible(hc_visible), .vc_visible(vc_visible),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pix_data(pix_data), .pix_valid(pix_valid)
   );

   // Synchronous single-port RAM model, read-before-write.
   always @(posedge clk_vga) begin
      if (mem_we === 1'b1) begin
         mem[mem_addr[5:0]] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      mem_rdata <= mem[mem_addr[5:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_vga);
      #1;
   endtask

   logic [18:0] pa [3];
   logic [11:0] pd [3];
   int          errs;
   int          base;

   initial begin
      pa[0] = 19'd0;  pd[0] = 12'hABC;
      pa[1] = 19'd63; pd[1] = 12'h123;
      pa[2] = 19'd18; pd[2] = 12'h456;

      rst_n = 1'b1; hc_visible = '0; vc_visible = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      clr_req = 1'b0; clr_color = '0;

      // ---------------- reset state ----------------
      #2 rst_n = 1'b0;
      #1;
      chk("rst_we",     32'(mem_we),    32'd0);
      chk("rst_addr",   32'(mem_addr),  32'd0);
      chk("rst_wdata",  32'(mem_wdata), 32'd0);
      chk("rst_busy",   32'(clr_busy),  32'd0);
      chk("rst_ready",  32'(wr_ready),  32'd1);
      chk("rst_pvalid", 32'(pix_valid), 32'd0);
      chk("rst_pdata",  32'(pix_data),  32'd0);
      @(posedge clk_vga); @(posedge clk_vga); #1;
      rst_n = 1'b1;

      // ---------------- buffered writes in blanking ----------------
      for (int j = 0; j < 3; j++) begin
         wr_valid = 1'b1; wr_addr = pa[j]; wr_data = pd[j];
         step();
         if (j == 0) chk("pre_idle_we", 32'(mem_we), 32'd0);
         else begin
            chk("pre_we",    32'(mem_we),    32'd1);
            chk("pre_addr",  32'(mem_addr),  32'(pa[j-1]));
            chk("pre_wdata", 32'(mem_wdata), 32'(pd[j-1]));
         end
      end
      wr_valid = 1'b0;
      step();
      chk("pre_addr2",  32'(mem_addr),  32'(pa[2]));
      chk("pre_wdata2", 32'(mem_wdata), 32'(pd[2]));
      step();
      chk("idle_we",   32'(mem_we),   32'd0);
      chk("idle_hold", 32'(mem_addr), 32'd18);

      // ---------------- first pixel ----------------
      hc_visible = 10'd1; vc_visible = 10'd1;
      step();
      chk("px1_addr", 32'(mem_addr), 32'd0);
      chk("px1_we",   32'(mem_we),   32'd0);
      hc_visible = 10'd0; vc_visible = 10'd0;
      step();
      chk("px1_valid", 32'(pix_valid), 32'd1);
      chk("px1_data",  32'(pix_data),  32'hABC);
      step();
      chk("blank_valid", 32'(pix_valid), 32'd0);
      chk("blank_data",  32'(pix_data),  32'd0);

      // ---------------- last pixel and mid-frame pixel ----------------
      hc_visible = 10'd16; vc_visible = 10'd4;
      step();
      chk("corner_addr", 32'(mem_addr), 32'd63);
      hc_visible = 10'd3; vc_visible = 10'd2;
      step();
      chk("mid_addr",     32'(mem_addr),  32'd18);
      chk("corner_valid", 32'(pix_valid), 32'd1);
      chk("corner_data",  32'(pix_data),  32'h123);
      hc_visible = 10'd0; vc_visible = 10'd0;
      step();
      chk("mid_data", 32'(pix_data),  32'h456);
      chk("mid_hold", 32'(mem_addr),  32'd18);
      step();
      chk("hc0_valid", 32'(pix_valid), 32'd0);

      // ---------------- FIFO fill during active, drain in blanking ----------------
      hc_visible = 10'd1; vc_visible = 10'd1;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_addr = 19'(40 + i); wr_data = 12'(12'h100 + i);
         chk("fifo_ready", 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
         chk("fifo_act_we", 32'(mem_we), 32'd0);
      end
      hc_visible = 10'd0; vc_visible = 10'd0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("drain_we",    32'(mem_we),    32'd1);
         chk("drain_addr",  32'(mem_addr),  32'(40 + k));
         chk("drain_wdata", 32'(mem_wdata), 32'(12'h100 + k));
         if (k == 0) chk("drain_ready", 32'(wr_ready), 32'd1);
         if (k == 1) wr_valid = 1'b0;
      end
      step();
      chk("drain_end_we", 32'(mem_we), 32'd0);

      // ---------------- full clear in blanking ----------------
      clr_req = 1'b1; clr_color = 12'h00F;
      step();
      clr_req = 1'b0;
      chk("clr_busy_set", 32'(clr_busy), 32'd1);
      chk("clr_first_we", 32'(mem_we),   32'd0);
      for (int k = 0; k < N; k++) begin
         step();
         chk("clr_we",    32'(mem_we),    32'd1);
         chk("clr_addr",  32'(mem_addr),  32'(k));
         chk("clr_wdata", 32'(mem_wdata), 32'h00F);
         chk("clr_busy",  32'(clr_busy),  (k < N - 1) ? 32'd1 : 32'd0);
      end
      step();
      chk("clr_end_we",   32'(mem_we),   32'd0);
      chk("clr_end_hold", 32'(mem_addr), 32'(N - 1));
      errs = 0;
      for (int a = 0; a < N; a++) if (mem[a] !== 12'h00F) errs++;
      chk("clr_fill", 32'(errs), 32'd0);

      // ---------------- clear interrupted by display and write ----------------
      clr_req = 1'b1; clr_color = 12'h0A5;
      step();
      clr_req = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("int_addr", 32'(mem_addr), 32'(k));
      end
      hc_visible = 10'd2; vc_visible = 10'd1;
      wr_valid = 1'b1; wr_addr = 19'd10; wr_data = 12'h777;
      step();
      chk("int_act_we",   32'(mem_we),   32'd0);
      chk("int_act_addr", 32'(mem_addr), 32'd1);
      chk("int_busy",     32'(clr_busy), 32'd1);
      wr_valid = 1'b0;
      step();
      chk("int_act_we2", 32'(mem_we), 32'd0);
      hc_visible = 10'd0; vc_visible = 10'd0;
      step();
      chk("int_wr_addr",  32'(mem_addr),  32'd10);
      chk("int_wr_wdata", 32'(mem_wdata), 32'h777);
      for (int k = 12; k < N; k++) begin
         step();
         chk("res_addr",  32'(mem_addr),  32'(k));
         chk("res_wdata", 32'(mem_wdata), 32'h0A5);
      end
      step();
      chk("res_busy", 32'(clr_busy), 32'd0);
      chk("res_we",   32'(mem_we),   32'd0);
      chk("res_addr10", 32'(mem[10]), 32'h777);
      errs = 0;
      for (int a = 0; a < N; a++) if (a != 10 && mem[a] !== 12'h0A5) errs++;
      chk("res_fill", 32'(errs), 32'd0);

      // ---------------- reset mid-clear with buffered entries ----------------
      clr_req = 1'b1; clr_color = 12'h0F0;
      step();
      clr_req = 1'b0;
      step(); step(); step();
      hc_visible = 10'd1; vc_visible = 10'd1;
      wr_valid = 1'b1; wr_addr = 19'd20; wr_data = 12'h0AA;
      step();
      wr_addr = 19'd21; wr_data = 12'h0BB;
      step();
      wr_valid = 1'b0;
      chk("pre_rst_busy", 32'(clr_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_we",     32'(mem_we),    32'd0);
      chk("mrst_addr",   32'(mem_addr),  32'd0);
      chk("mrst_wdata",  32'(mem_wdata), 32'd0);
      chk("mrst_busy",   32'(clr_busy),  32'd0);
      chk("mrst_ready",  32'(wr_ready),  32'd1);
      chk("mrst_pvalid", 32'(pix_valid), 32'd0);
      chk("mrst_pdata",  32'(pix_data),  32'd0);
      hc_visible = 10'd0; vc_visible = 10'd0;
      step(); step();
      base = we_cnt;
      rst_n = 1'b1;
      repeat (40) step();
      chk("post_rst_writes", 32'(we_cnt - base), 32'd0);
      chk("post_rst_busy",   32'(clr_busy),      32'd0);

      // ---------------- normal operation after reset ----------------
      wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 12'h321;
      step();
      wr_valid = 1'b0;
      chk("post_we0", 32'(mem_we), 32'd0);
      step();
      chk("post_we",    32'(mem_we),    32'd1);
      chk("post_addr",  32'(mem_addr),  32'd5);
      chk("post_wdata", 32'(mem_wdata), 32'h321);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter ADDR_W, default 19, frame-buffer address width.
REQ-004 Parameter DATA_W, default 12, pixel width (RGB 4:4:4).
REQ-005 Parameter WBUF_DEPTH, default 4 (power of 2), write-buffer entries.
REQ-006 clk_vga  in  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 hc_visible  in  10  column from the timing driver; 0 means not visible.
REQ-009 vc_visible  in  10  line from the timing driver; 0 means not visible.
REQ-010 wr_valid / wr_ready  in / out  1 / 1  writer handshake; a transfer occurs when both are 1 on a clock edge.
REQ-011 wr_addr / wr_data  in  ADDR_W / DATA_W  writer pixel address and value.
REQ-012 clr_req  in  1  single-cycle pulse requesting a full-frame clear.
REQ-013 clr_color  in  DATA_W  fill value, sampled on the cycle clr_req is accepted.
REQ-014 clr_busy  out  1  high while a clear is in progress.
REQ-015 mem_addr / mem_we / mem_wdata  out  ADDR_W / 1 / DATA_W  single-port frame-buffer port, all registered.
REQ-016 mem_rdata  in  DATA_W  read data, valid one cycle after the address is presented.
REQ-017 pix_data / pix_valid  out  DATA_W / 1  display pixel and qualifier.

Function
REQ-018 Active region SHALL be hc_visible!=0 AND vc_visible!=0; display address SHALL be (vc_visible-1)*H_ACTIVE+(hc_visible-1), computed at ADDR_W bits without truncation.
REQ-019 Port owner states: ACTIVE (display read), WRITE (buffer drain), CLEAR (fill), IDLE.
REQ-020 Priority each cycle: active region -> ACTIVE; else buffer non-empty -> WRITE; else clr_busy -> CLEAR; else IDLE.
REQ-021 In ACTIVE, mem_we SHALL be 0 and mem_addr the display address of the same cycle.
REQ-022 pix_data/pix_valid SHALL appear 2 cycles after the hc/vc sample (1 registered address + 1 memory); outside active they SHALL be 0.
REQ-023 Write buffer SHALL be a FIFO of WBUF_DEPTH entries; wr_ready = not full, regardless of region.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; when full, a pop SHALL raise wr_ready on the next cycle, with no combinational path from pop to wr_ready.
REQ-025 WRITE SHALL pop one entry per cycle, mem_we=1, in acceptance order.
REQ-026 Accepted clr_req SHALL set clr_busy the next cycle and load clear pointer 0; each CLEAR cycle writes clr_color at the pointer and increments it.
REQ-027 After writing address H_ACTIVE*V_ACTIVE-1, clr_busy SHALL drop the next cycle and the pointer SHALL return to 0.
REQ-028 clr_req while clr_busy SHALL restart the clear from 0 with the new clr_color.
REQ-029 A clear pauses (pointer held) during ACTIVE and WRITE, resuming exactly where it stopped.
REQ-030 A buffered write issued after a clear has written that address SHALL prevail (later write wins).
REQ-031 IDLE: mem_we=0, mem_addr holds its last value.

Reset
REQ-032 rst_n low SHALL immediately force mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0, pix_valid=0, clr_busy=0, FIFO empty (wr_ready=1), clear pointer 0, state IDLE.
REQ-033 Reset during a clear or drain SHALL discard all pending work; no write SHALL follow deassertion until a new request.
REQ-034 After deassertion, normal operation SHALL start on the first rising edge.

Verification
REQ-035 hc=1,vc=1 with mem_rdata=0xABC next cycle -> mem_addr=0, mem_we=0, pix_data=0xABC, pix_valid=1 two cycles after the sample.
REQ-036 hc=640,vc=480 -> mem_addr=307199; hc=0 -> pix_valid=0 two cycles later.
REQ-037 5 back-to-back writes in active region -> 4 accepted, wr_ready=0 on 5th; at blanking 4 writes in order on consecutive cycles, then 5th accepted.
REQ-038 clr_req, clr_color=0x00F, blanking only -> 307200 writes of 0x00F at 0..307199, clr_busy falls one cycle after last.
REQ-039 Clear interrupted by active line and by buffered write to address 10 (after clear passed 10) -> pointer resumes with no skip or repeat; address 10 final value = written data.
REQ-040 rst_n low mid-clear with 2 buffered entries -> outputs per REQ-032 immediately; no mem_we after release.
